// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, instruction formats, decode-stage FSM states
// and the fixed-width control payload of the ID/EX stage.
package rv_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_HAZARD
    } state_e;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic             illegal;
    } ex_ctrl_t;

    // JALR and loads share the I-type immediate layout with the ALU-immediate group
    function automatic fmt_e decode_fmt(input logic [6:0] op);
        fmt_e f;
        f = FMT_ILL;
        case (op)
            OP_R:                      f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                  f = FMT_S;
            OP_BRANCH:                 f = FMT_B;
            OP_LUI, OP_AUIPC:          f = FMT_U;
            OP_JAL:                    f = FMT_J;
            default:                   f = FMT_ILL;
        endcase
        return f;
    endfunction

    function automatic logic reads_rs1(input fmt_e f);
        return (f == FMT_R) || (f == FMT_I) || (f == FMT_S) || (f == FMT_B);
    endfunction

    function automatic logic reads_rs2(input fmt_e f);
        return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the format-specific immediate field of an
// instruction and sign-extends it to XLEN; R-type and illegal opcodes yield zero.
module imm_gen
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ILEN-1:0] instr_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (decode_fmt(instr_i[6:0]))
            FMT_I:   imm_o = XLEN'($signed(instr_i[31:20]));
            FMT_S:   imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            FMT_B:   imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                            instr_i[11:8], 1'b0}));
            FMT_U:   imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            FMT_J:   imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                            instr_i[30:21], 1'b0}));
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage controller: one-entry ID slot, load-use scoreboard with hazard stall,
// and a registered ID/EX stage behind a valid/ready handshake, squashed by flush.
module decode_issue_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [ILEN-1:0]  if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [6:0]       ex_opcode,
    output logic [REG_W-1:0] ex_rd,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic             ex_illegal,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e            state_q, state_d;
    logic              slot_valid_q, slot_valid_d;
    logic [ILEN-1:0]   slot_instr_q, slot_instr_d;
    logic [XLEN-1:0]   slot_pc_q, slot_pc_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              ex_valid_q, ex_valid_d;
    ex_ctrl_t          ex_ctrl_q, ex_ctrl_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;

    logic [6:0]        id_op;
    logic [REG_W-1:0]  id_rd, id_rs1, id_rs2;
    fmt_e              id_fmt;
    logic [XLEN-1:0]   id_imm;
    logic              rs1_busy_c, rs2_busy_c, hazard_c, issue_c, accept_c;

    assign id_op  = slot_instr_q[6:0];
    assign id_rd  = slot_instr_q[11:7];
    assign id_rs1 = slot_instr_q[19:15];
    assign id_rs2 = slot_instr_q[24:20];
    assign id_fmt = decode_fmt(id_op);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (slot_instr_q),
        .imm_o   (id_imm)
    );

    // Hazard looks at registered busy bits only; x0 is never marked busy
    assign rs1_busy_c = reads_rs1(id_fmt) && (id_rs1 != '0) && busy_q[id_rs1];
    assign rs2_busy_c = reads_rs2(id_fmt) && (id_rs2 != '0) && busy_q[id_rs2];
    assign hazard_c   = slot_valid_q && (rs1_busy_c || rs2_busy_c);
    assign issue_c    = slot_valid_q && !hazard_c && (!ex_valid_q || ex_ready) && !flush;
    assign if_ready   = !flush && (!slot_valid_q || issue_c);
    assign accept_c   = if_valid && if_ready;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_imm_d     = ex_imm_q;
        ex_pc_d      = ex_pc_q;
        busy_d       = busy_q;
        stall_d      = stall_q;

        if (flush) begin
            slot_valid_d = 1'b0;
        end else if (accept_c) begin
            slot_valid_d = 1'b1;
            slot_instr_d = if_instr;
            slot_pc_d    = if_pc;
        end else if (issue_c) begin
            slot_valid_d = 1'b0;
        end

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue_c) begin
            ex_valid_d        = 1'b1;
            ex_ctrl_d.opcode  = id_op;
            ex_ctrl_d.rd      = id_rd;
            ex_ctrl_d.rs1     = id_rs1;
            ex_ctrl_d.rs2     = id_rs2;
            ex_ctrl_d.funct3  = slot_instr_q[14:12];
            ex_ctrl_d.funct7  = slot_instr_q[31:25];
            ex_ctrl_d.illegal = (id_fmt == FMT_ILL);
            ex_imm_d          = id_imm;
            ex_pc_d           = slot_pc_q;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end

        // Writeback clear first so a same-cycle load issue to that register wins
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue_c && (id_op == OP_LOAD) && (id_rd != '0)) begin
            busy_d[id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (hazard_c && !flush && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Slot occupancy FSM; tracks whether the held instruction is waiting on the scoreboard
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) state_d = ST_FULL;
                end
                ST_FULL, ST_HAZARD: begin
                    if (hazard_c)                   state_d = ST_HAZARD;
                    else if (issue_c && !accept_c)  state_d = ST_EMPTY;
                    else                            state_d = ST_FULL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid_q <= 1'b0;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            busy_q       <= '0;
            stall_q      <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_q      <= ex_pc_d;
            busy_q       <= busy_d;
            stall_q      <= stall_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_opcode  = ex_ctrl_q.opcode;
    assign ex_rd      = ex_ctrl_q.rd;
    assign ex_rs1     = ex_ctrl_q.rs1;
    assign ex_rs2     = ex_ctrl_q.rs2;
    assign ex_funct3  = ex_ctrl_q.funct3;
    assign ex_funct7  = ex_ctrl_q.funct7;
    assign ex_illegal = ex_ctrl_q.illegal;
    assign ex_imm     = ex_imm_q;
    assign ex_pc      = ex_pc_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: decode vector table, directed multi-cycle
// sequences and random traffic, all against a cycle-level reference model.
module tb_decode_issue_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 4;
    localparam int          SAT  = (1 << CW) - 1;

    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADD   = 32'h00228333;
    localparam logic [31:0] I_ADDI7 = 32'hFFF00393;

    logic            clk;
    logic            rst_n;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [6:0]      ex_opcode;
    logic [4:0]      ex_rd;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic            ex_illegal;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [CW-1:0]   stall_cnt;

    decode_issue_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_opcode  (ex_opcode),
        .ex_rd      (ex_rd),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_funct3  (ex_funct3),
        .ex_funct7  (ex_funct7),
        .ex_imm     (ex_imm),
        .ex_pc      (ex_pc),
        .ex_illegal (ex_illegal),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: the held instruction, the one sitting in execute, busy regs
    bit          m_sv;
    logic [31:0] m_si, m_sp;
    bit          m_ev;
    logic [31:0] m_ei, m_ep, m_eimm;
    bit          m_eill;
    bit          m_busy [32];
    int          m_stall;
    logic [31:0] pc_ctr;

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic [31:0] imm;
        bit          ill;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    endfunction

    function automatic bit uses1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1100111};
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    // Immediate built arithmetically from the field layouts using a signed view of the word
    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        int s;
        s = $signed(x);
        case (x[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return 32'(s >>> 20);
            7'b0100011: return 32'((s >>> 25) << 5) | 32'(x[11:7]);
            7'b1100011: return 32'((s >>> 31) << 12) | (32'(x[7]) << 11) |
                               (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
            7'b0110111, 7'b0010111: return x & 32'hFFFFF000;
            7'b1101111: return 32'((s >>> 31) << 20) | (32'(x[19:12]) << 12) |
                               (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_hazard();
        logic [4:0] r1, r2;
        r1 = m_si[19:15];
        r2 = m_si[24:20];
        return m_sv && ((uses1(m_si[6:0]) && r1 != 0 && m_busy[r1]) ||
                        (uses2(m_si[6:0]) && r2 != 0 && m_busy[r2]));
    endfunction

    function automatic logic [31:0] mk_addi(input int rd, input int imm);
        return {12'(imm), 5'd0, 3'd0, 5'(rd), 7'b0010011};
    endfunction

    task automatic check_outs();
        check("ex_valid", 64'(ex_valid), 64'(m_ev));
        check("ex_imm", 64'(ex_imm), 64'(m_eimm));
        check("ex_pc", 64'(ex_pc), 64'(m_ep));
        check("ex_fields",
              64'({ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_funct7, ex_illegal}),
              64'({m_ei[6:0], m_ei[11:7], m_ei[19:15], m_ei[24:20], m_ei[14:12],
                   m_ei[31:25], m_eill}));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        m_sv = 0; m_si = '0; m_sp = '0; m_ev = 0; m_ei = '0; m_ep = '0; m_eimm = '0;
        m_eill = 0; m_stall = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        rst_n = 1'b1;
        check_outs();
    endtask

    // One clock: drive, check if_ready, advance model, clock, check registered outputs
    task automatic cyc(input bit ifv, input logic [31:0] ins, input bit fl, input bit exr,
                       input bit wbv, input logic [4:0] wbrd);
        bit haz, iss, ifr, acc;
        if_valid = ifv; if_instr = ins; if_pc = pc_ctr; flush = fl; ex_ready = exr;
        wb_valid = wbv; wb_rd = wbrd;
        #3;
        haz = m_hazard();
        iss = m_sv && !haz && (!m_ev || exr) && !fl;
        ifr = !fl && (!m_sv || iss);
        acc = ifv && ifr;
        check("if_ready", 64'(if_ready), 64'(ifr));
        if (haz && !fl && m_stall < SAT) m_stall++;
        if (wbv) m_busy[wbrd] = 0;
        if (iss && m_si[6:0] == 7'b0000011 && m_si[11:7] != 0) m_busy[m_si[11:7]] = 1;
        if (fl) m_ev = 0;
        else if (iss) begin
            m_ev = 1; m_ei = m_si; m_ep = m_sp; m_eimm = ref_imm(m_si);
            m_eill = !is_legal(m_si[6:0]);
        end else if (exr) m_ev = 0;
        if (fl) m_sv = 0;
        else if (acc) begin m_sv = 1; m_si = ins; m_sp = pc_ctr; end
        else if (iss) m_sv = 0;
        pc_ctr = pc_ctr + 32'd4;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic idle(input bit exr);
        cyc(0, 32'h0, 0, exr, 0, 5'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        logic [31:0] ri;
        logic [6:0]  ops [10];

        tbl[0]  = '{"addi_m1",   32'hFFF00393, 32'hFFFFFFFF, 0};
        tbl[1]  = '{"sw_p8",     32'h0050A423, 32'h00000008, 0};
        tbl[2]  = '{"beq_m4",    32'hFE000EE3, 32'hFFFFFFFC, 0};
        tbl[3]  = '{"lui",       32'h123451B7, 32'h12345000, 0};
        tbl[4]  = '{"auipc",     32'hFFFFF097, 32'hFFFFF000, 0};
        tbl[5]  = '{"jal_m8",    32'hFF9FF0EF, 32'hFFFFFFF8, 0};
        tbl[6]  = '{"jalr_0",    32'h00008067, 32'h00000000, 0};
        tbl[7]  = '{"jalr_m2048",32'h80008067, 32'hFFFFF800, 0};
        tbl[8]  = '{"add",       32'h00228333, 32'h00000000, 0};
        tbl[9]  = '{"ill_zero",  32'h00000000, 32'h00000000, 1};
        tbl[10] = '{"sb_m1",     32'hFE110FA3, 32'hFFFFFFFF, 0};
        tbl[11] = '{"bne_p16",   32'h00209863, 32'h00000010, 0};
        tbl[12] = '{"ill_ones",  32'hFFFFFFFF, 32'h00000000, 1};
        tbl[13] = '{"addi_p2047",32'h7FF00093, 32'h000007FF, 0};

        pc_ctr = 32'h1000;
        do_reset();

        // Decode table: accept at one edge, result visible after the next
        foreach (tbl[i]) begin
            cyc(1, tbl[i].instr, 0, 1, 0, 5'd0);
            cyc(0, 32'h0, 0, 1, 0, 5'd0);
            check({tbl[i].nm, "_valid"}, 64'(ex_valid), 64'd1);
            check({tbl[i].nm, "_imm"}, 64'(ex_imm), 64'(tbl[i].imm));
            check({tbl[i].nm, "_ill"}, 64'(ex_illegal), 64'(tbl[i].ill));
        end

        // Streamed addi: one per cycle
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, I_ADDI7, 0, 1, 0, 5'd0);
        check("stream_rd", 64'(ex_rd), 64'd7);
        check("stream_imm", 64'(ex_imm), 64'hFFFFFFFF);
        check("stream_valid", 64'(ex_valid), 64'd1);

        // Load-use hazard held until writeback, then issue the cycle after
        do_reset();
        cyc(1, I_LW, 0, 1, 0, 5'd0);
        cyc(1, I_ADD, 0, 1, 0, 5'd0);
        check("lu_ready_blocked", 64'(if_ready), 64'd0);
        idle(1);
        idle(1);
        check("lu_stall2", 64'(stall_cnt), 64'd2);
        cyc(0, 32'h0, 0, 1, 1, 5'd5);
        check("lu_stall3", 64'(stall_cnt), 64'd3);
        check("lu_not_yet", 64'(ex_valid), 64'd0);
        idle(1);
        check("lu_issue_rd", 64'(ex_rd), 64'd6);
        check("lu_issue_valid", 64'(ex_valid), 64'd1);
        check("lu_stall_frozen", 64'(stall_cnt), 64'd3);

        // Back-pressure: fields stable, nothing lost or duplicated
        do_reset();
        cyc(1, mk_addi(1, 1), 0, 0, 0, 5'd0);
        cyc(1, mk_addi(2, 2), 0, 0, 0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, mk_addi(3, 3), 0, 0, 0, 5'd0);
            check("bp_hold_rd", 64'(ex_rd), 64'd1);
            check("bp_hold_imm", 64'(ex_imm), 64'd1);
        end
        idle(1);
        check("bp_next_rd", 64'(ex_rd), 64'd2);
        idle(1);
        check("bp_drained", 64'(ex_valid), 64'd0);

        // Flush with both stages full; the earlier load stays busy
        do_reset();
        cyc(1, I_LW, 0, 1, 0, 5'd0);
        cyc(1, mk_addi(1, 9), 0, 0, 0, 5'd0);
        cyc(0, 32'h0, 1, 0, 0, 5'd0);
        check("fl_ex_cleared", 64'(ex_valid), 64'd0);
        cyc(1, I_ADD, 0, 1, 0, 5'd0);
        check("fl_slot_was_empty", 64'(ex_valid), 64'd0);
        idle(1);
        check("fl_busy_kept", 64'(stall_cnt), 64'd1);
        cyc(0, 32'h0, 0, 1, 1, 5'd5);
        idle(1);
        check("fl_add_issued", 64'(ex_rd), 64'd6);

        // Counter saturation
        do_reset();
        cyc(1, I_LW, 0, 1, 0, 5'd0);
        cyc(1, I_ADD, 0, 1, 0, 5'd0);
        for (int i = 0; i < SAT + 5; i++) idle(1);
        check("sat_cnt", 64'(stall_cnt), 64'(SAT));
        cyc(0, 32'h0, 0, 1, 1, 5'd5);
        idle(1);
        check("sat_issue", 64'(ex_rd), 64'd6);

        // Random traffic against the model, small register range to provoke hazards
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b1101111, 7'b1100111, 7'b0001011};
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ri = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 9)];
            ri[11:7]  = 5'($urandom_range(0, 7));
            ri[19:15] = 5'($urandom_range(0, 7));
            ri[24:20] = 5'($urandom_range(0, 7));
            cyc(($urandom_range(0, 3) != 0), ri, ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                5'($urandom_range(0, 7)));
            if (n == 1500) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
